// File: rtl/switch_debounce_sync.sv
// Two-flop synchroniser plus per-channel stability-counter debouncer for X,Y,Z,K,M.
// Optional DEB_EDGE_EN macro adds registered per-channel rise/fall pulse ports.
module switch_debounce_sync #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       x_raw,
   input  logic       y_raw,
   input  logic       z_raw,
   input  logic       k_raw,
   input  logic       m_raw,
   output logic       X,
   output logic       Y,
   output logic       Z,
   output logic       K,
   output logic       M,
   output logic       valid,
   output logic       chg
`ifdef DEB_EDGE_EN
   ,
   output logic [4:0] rise,
   output logic [4:0] fall
`endif
);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] init_cnt;
   logic [CNT_W-1:0] init_cnt_nxt;
   logic             run;

   logic [4:0]       raw;
   logic [4:0]       s1;
   logic [4:0]       s2;
   logic [4:0]       deb;
   logic [4:0]       flip;

   // Bit order [4]=X ... [0]=M throughout.
   assign raw = {x_raw, y_raw, z_raw, k_raw, m_raw};
   assign run = (state == ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      if (state == ST_INIT) begin
         init_cnt_nxt = init_cnt + CNT_W'(1);
         if (init_cnt == LAST) begin
            state_nxt = ST_RUN;
         end
      end
   end

   for (genvar g = 0; g < 5; g++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic             q;
      logic             mis;

      assign mis = s2[g] ^ q;

      // INIT tracks the synchronised level directly so RUN starts from the power-on value.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
            q   <= 1'b0;
         end else if (!run) begin
            cnt <= '0;
            q   <= s2[g];
         end else if (!mis) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt <= '0;
            q   <= s2[g];
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end

      assign deb[g]  = q;
      assign flip[g] = run & mis & (cnt == LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chg <= 1'b0;
      end else begin
         chg <= |flip;
      end
   end

`ifdef DEB_EDGE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise <= '0;
         fall <= '0;
      end else begin
         rise <= flip & s2;
         fall <= flip & ~s2;
      end
   end
`endif

   assign X     = deb[4];
   assign Y     = deb[3];
   assign Z     = deb[2];
   assign K     = deb[1];
   assign M     = deb[0];
   assign valid = run;

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Directed self-checking bench for switch_debounce_sync with STABLE_CYCLES=4.
module tb_switch_debounce_sync;

   logic       clk;
   logic       rst_n;
   logic       x_raw, y_raw, z_raw, k_raw, m_raw;
   logic       X, Y, Z, K, M;
   logic       valid;
   logic       chg;
`ifdef DEB_EDGE_EN
   logic [4:0] rise;
   logic [4:0] fall;
`endif

   int unsigned errors;
   int unsigned checks;

   logic [4:0] outs;
   logic [6:0] obs;
   assign outs = {X, Y, Z, K, M};
   assign obs  = {X, Y, Z, K, M, valid, chg};

   switch_debounce_sync #(
      .STABLE_CYCLES(4),
      .CNT_W(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .x_raw(x_raw),
      .y_raw(y_raw),
      .z_raw(z_raw),
      .k_raw(k_raw),
      .m_raw(m_raw),
      .X(X),
      .Y(Y),
      .Z(Z),
      .K(K),
      .M(M),
      .valid(valid),
      .chg(chg)
`ifdef DEB_EDGE_EN
      ,
      .rise(rise),
      .fall(fall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] exp;
      rst_n = 1'b0;
      {x_raw, y_raw, z_raw, k_raw, m_raw} = 5'b11111;
      tick();
      tick();
      checks++;
      if (obs !== 7'b0000000) begin
         errors++;
         $display("FAIL reset_hold: got %b want %b", obs, 7'b0000000);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp = {(e >= 3) ? 5'b11111 : 5'b00000, (e >= 4), 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_release edge %0d: got %b want %b", e, obs, exp);
         end
`ifdef DEB_EDGE_EN
         checks++;
         if ({rise, fall} !== 10'b0) begin
            errors++;
            $display("FAIL init_edges edge %0d: got %b want 0", e, {rise, fall});
         end
`endif
      end
   endtask

   task automatic test_settle_low();
      {x_raw, y_raw, z_raw, k_raw, m_raw} = 5'b00000;
      for (int e = 1; e <= 8; e++) tick();
      checks++;
      if (obs !== 7'b0000010) begin
         errors++;
         $display("FAIL settle_low: got %b want %b", obs, 7'b0000010);
      end
   endtask

   task automatic test_single();
      logic [6:0] exp;
      x_raw = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp = {(e >= 6) ? 5'b10000 : 5'b00000, 1'b1, (e == 6)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL single_x edge %0d: got %b want %b", e, obs, exp);
         end
`ifdef DEB_EDGE_EN
         checks++;
         if ({rise, fall} !== {(e == 6) ? 5'b10000 : 5'b00000, 5'b00000}) begin
            errors++;
            $display("FAIL single_rise edge %0d: got %b want %b", e, {rise, fall},
                     {(e == 6) ? 5'b10000 : 5'b00000, 5'b00000});
         end
`endif
      end
   endtask

   task automatic test_bounce();
      logic [6:0] exp;
      x_raw = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         exp = {(e >= 6) ? 5'b00000 : 5'b10000, 1'b1, (e == 6)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL x_fall edge %0d: got %b want %b", e, obs, exp);
         end
`ifdef DEB_EDGE_EN
         checks++;
         if ({rise, fall} !== {5'b00000, (e == 6) ? 5'b10000 : 5'b00000}) begin
            errors++;
            $display("FAIL x_fall_pulse edge %0d: got %b want %b", e, {rise, fall},
                     {5'b00000, (e == 6) ? 5'b10000 : 5'b00000});
         end
`endif
      end
      for (int t = 0; t < 10; t++) begin
         x_raw = ~x_raw;
         for (int e = 0; e < 2; e++) begin
            tick();
            checks++;
            if (obs !== 7'b0000010) begin
               errors++;
               $display("FAIL bounce toggle %0d: got %b want %b", t, obs, 7'b0000010);
            end
         end
      end
      for (int e = 1; e <= 6; e++) begin
         tick();
         checks++;
         if (obs !== 7'b0000010) begin
            errors++;
            $display("FAIL bounce_tail edge %0d: got %b want %b", e, obs, 7'b0000010);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0]  exp;
      int unsigned pulses;
      pulses = 0;
      y_raw = 1'b1;
      m_raw = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (chg === 1'b1) pulses++;
         exp = {(e >= 6) ? 5'b01001 : 5'b00000, 1'b1, (e == 6)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL y_m_same edge %0d: got %b want %b", e, obs, exp);
         end
`ifdef DEB_EDGE_EN
         checks++;
         if ({rise, fall} !== {(e == 6) ? 5'b01001 : 5'b00000, 5'b00000}) begin
            errors++;
            $display("FAIL y_m_rise edge %0d: got %b want %b", e, {rise, fall},
                     {(e == 6) ? 5'b01001 : 5'b00000, 5'b00000});
         end
`endif
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL y_m_pulses: got %0d want 1", pulses);
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] exp;
      k_raw = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if (obs !== 7'b0100110) begin
         errors++;
         $display("FAIL k_window: got %b want %b", obs, 7'b0100110);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 7'b0000000) begin
         errors++;
         $display("FAIL mid_reset_async: got %b want %b", obs, 7'b0000000);
      end
      tick();
      tick();
      checks++;
      if (obs !== 7'b0000000) begin
         errors++;
         $display("FAIL mid_reset_hold: got %b want %b", obs, 7'b0000000);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         exp = {(e >= 3) ? 5'b01011 : 5'b00000, (e >= 4), 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL mid_reset_init edge %0d: got %b want %b", e, obs, exp);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      {x_raw, y_raw, z_raw, k_raw, m_raw} = 5'b00000;
      test_reset();
      test_settle_low();
      test_single();
      test_bounce();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
